// File: rtl/n2_dta_ctl.sv
// n2_dta_ctl: access controller for the 4-way, 128-set D-cache tag array.
// After reset it sweeps the array to invalidate every entry. It then
// serves LSU lookups and miss-path fills; fills take priority.
// Array-facing outputs are registered. Lookup results appear three
// cycles after acceptance.
// Optional feature macro: DTA_PLRU_EN. When defined, a per-set tree
// pseudo-LRU replaces the global round-robin replacement counter.
module n2_dta_ctl #(
    parameter int NUM_SETS = 128,
    parameter int TAG_W    = 29
) (
    input  logic             l2clk,
    input  logic             reset,
    input  logic             lkup_vld,
    input  logic [6:0]       lkup_index,
    input  logic [TAG_W-1:0] lkup_tag,
    output logic             lkup_rdy,
    input  logic             fill_vld,
    input  logic [6:0]       fill_index,
    input  logic [TAG_W-1:0] fill_tag,
    input  logic             fill_valid,
    input  logic             fill_use_repl,
    input  logic [1:0]       fill_way,
    output logic             fill_rdy,
    output logic [1:0]       fill_way_used,
    output logic             hit_vld,
    output logic             hit,
    output logic [1:0]       hit_way,
    output logic             multi_hit,
    output logic             init_done,
    output logic [6:0]       index0_x,
    output logic [6:0]       index1_x,
    output logic             index_sel_x,
    output logic [1:0]       wrway_x,
    output logic             rdreq_x,
    output logic             wrreq_x,
    output logic [TAG_W:0]   wrtag_x,
    output logic             dta_clken,
    input  logic [TAG_W:0]   rdtag_w0_y,
    input  logic [TAG_W:0]   rdtag_w1_y,
    input  logic [TAG_W:0]   rdtag_w2_y,
    input  logic [TAG_W:0]   rdtag_w3_y
);

    typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

    state_t           state, state_d;
    logic [8:0]       sweep_cnt, sweep_cnt_d;
    logic             init_done_d;
    logic [6:0]       index0_d, index1_d;
    logic             index_sel_d, rdreq_d, wrreq_d, clken_d;
    logic [1:0]       wrway_d;
    logic [TAG_W:0]   wrtag_d;
    logic             lkup_acc, fill_acc;
    logic [1:0]       repl_way;

    logic             vld_p1, vld_p2;
    logic [TAG_W-1:0] tag_p1, tag_p2;
    logic [TAG_W:0]   rdtag [4];
    logic [3:0]       match;
    logic [1:0]       first_way;

    assign rdtag[0] = rdtag_w0_y;
    assign rdtag[1] = rdtag_w1_y;
    assign rdtag[2] = rdtag_w2_y;
    assign rdtag[3] = rdtag_w3_y;

    // Next-state, handshakes and next array command. The sweep leaves INIT
    // only once the write for the last set/way is already on the array pins.
    always_comb begin
        state_d     = state;
        sweep_cnt_d = sweep_cnt;
        init_done_d = init_done;
        index0_d    = '0;
        index1_d    = '0;
        index_sel_d = 1'b0;
        rdreq_d     = 1'b0;
        wrreq_d     = 1'b0;
        clken_d     = 1'b0;
        wrway_d     = '0;
        wrtag_d     = '0;
        lkup_rdy    = 1'b0;
        fill_rdy    = 1'b0;
        lkup_acc    = 1'b0;
        fill_acc    = 1'b0;
        case (state)
            INIT: begin
                if (wrreq_x && ({index1_x, wrway_x} == 9'h1FF)) begin
                    state_d     = RUN;
                    init_done_d = 1'b1;
                    sweep_cnt_d = '0;
                end else begin
                    wrreq_d     = 1'b1;
                    index_sel_d = 1'b1;
                    clken_d     = 1'b1;
                    index1_d    = sweep_cnt[8:2];
                    wrway_d     = sweep_cnt[1:0];
                    sweep_cnt_d = sweep_cnt + 9'd1;
                end
            end
            RUN: begin
                fill_rdy = 1'b1;
                lkup_rdy = ~fill_vld;
                fill_acc = fill_vld;
                lkup_acc = lkup_vld & ~fill_vld;
                if (fill_acc) begin
                    wrreq_d     = 1'b1;
                    index_sel_d = 1'b1;
                    clken_d     = 1'b1;
                    index1_d    = fill_index;
                    wrtag_d     = {fill_valid, fill_tag};
                    wrway_d     = fill_use_repl ? repl_way : fill_way;
                end else if (lkup_acc) begin
                    rdreq_d  = 1'b1;
                    clken_d  = 1'b1;
                    index0_d = lkup_index;
                end
            end
            default: state_d = INIT;
        endcase
    end

    // State, sweep counter and registered array command.
    always_ff @(posedge l2clk) begin
        if (reset) begin
            state       <= INIT;
            sweep_cnt   <= '0;
            init_done   <= 1'b0;
            index0_x    <= '0;
            index1_x    <= '0;
            index_sel_x <= 1'b0;
            rdreq_x     <= 1'b0;
            wrreq_x     <= 1'b0;
            dta_clken   <= 1'b0;
            wrway_x     <= '0;
            wrtag_x     <= '0;
        end else begin
            state       <= state_d;
            sweep_cnt   <= sweep_cnt_d;
            init_done   <= init_done_d;
            index0_x    <= index0_d;
            index1_x    <= index1_d;
            index_sel_x <= index_sel_d;
            rdreq_x     <= rdreq_d;
            wrreq_x     <= wrreq_d;
            dta_clken   <= clken_d;
            wrway_x     <= wrway_d;
            wrtag_x     <= wrtag_d;
        end
    end

    // Way chosen by the most recent accepted fill.
    always_ff @(posedge l2clk) begin
        if (reset) begin
            fill_way_used <= '0;
        end else if (fill_acc) begin
            fill_way_used <= wrway_d;
        end
    end

    // Lookup tag travels with the request until the array data returns.
    always_ff @(posedge l2clk) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            tag_p1 <= '0;
            tag_p2 <= '0;
        end else begin
            vld_p1 <= lkup_acc;
            vld_p2 <= vld_p1;
            if (lkup_acc) begin
                tag_p1 <= lkup_tag;
            end
            tag_p2 <= tag_p1;
        end
    end

    // Per-way tag compare and lowest-way priority pick.
    always_comb begin
        for (int w = 0; w < 4; w++) begin
            match[w] = rdtag[w][TAG_W] && (rdtag[w][TAG_W-1:0] == tag_p2);
        end
        first_way = 2'd0;
        if (match[0])      first_way = 2'd0;
        else if (match[1]) first_way = 2'd1;
        else if (match[2]) first_way = 2'd2;
        else if (match[3]) first_way = 2'd3;
    end

    // Registered lookup result, one-cycle hit_vld pulse.
    always_ff @(posedge l2clk) begin
        if (reset) begin
            hit_vld   <= 1'b0;
            hit       <= 1'b0;
            hit_way   <= '0;
            multi_hit <= 1'b0;
        end else begin
            hit_vld <= vld_p2;
            if (vld_p2) begin
                hit       <= |match;
                hit_way   <= first_way;
                multi_hit <= (match & (match - 4'd1)) != 4'd0;
            end
        end
    end

`ifdef DTA_PLRU_EN
    // Tree bits: [0] root (1 = victim in ways 2/3), [1] ways 0/1, [2] ways 2/3.
    logic [2:0] plru [NUM_SETS];
    logic [6:0] idx_p1, idx_p2, hit_idx;
    logic [2:0] fill_bits;

    function automatic logic [2:0] plru_touch(input logic [2:0] bits, input logic [1:0] way);
        logic [2:0] nb;
        nb    = bits;
        nb[0] = ~way[1];
        if (way[1]) nb[2] = ~way[0];
        else        nb[1] = ~way[0];
        return nb;
    endfunction

    // Victim for the set being filled, following the tree bits.
    always_comb begin
        fill_bits = plru[fill_index];
        repl_way  = fill_bits[0] ? {1'b1, fill_bits[2]} : {1'b0, fill_bits[1]};
    end

    // Set index follows the lookup so a hit can update its own set.
    always_ff @(posedge l2clk) begin
        if (reset) begin
            idx_p1  <= '0;
            idx_p2  <= '0;
            hit_idx <= '0;
        end else begin
            if (lkup_acc) begin
                idx_p1 <= lkup_index;
            end
            idx_p2  <= idx_p1;
            hit_idx <= idx_p2;
        end
    end

    // Tree update on hits and fills; the later fill write wins a same-set clash.
    always_ff @(posedge l2clk) begin
        if (reset) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                plru[s] <= '0;
            end
        end else begin
            if (hit_vld && hit) begin
                plru[hit_idx] <= plru_touch(plru[hit_idx], hit_way);
            end
            if (fill_acc) begin
                plru[fill_index] <= plru_touch(plru[fill_index], wrway_d);
            end
        end
    end
`else
    logic [1:0] rr_cnt;

    assign repl_way = rr_cnt;

    // Global round-robin victim, advanced by each replacement fill.
    always_ff @(posedge l2clk) begin
        if (reset) begin
            rr_cnt <= '0;
        end else if (fill_acc && fill_use_repl) begin
            rr_cnt <= rr_cnt + 2'd1;
        end
    end
`endif

endmodule
